// File: rtl/count_ctrl.sv
// Start/pause/clear controller for a two-digit BCD counter advanced by div_clk ticks.
// Counts 0..MAX_COUNT and rolls over with a one-cycle wrap pulse; all outputs are registered.
module count_ctrl #(
    parameter int MAX_COUNT = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clk,
    input  logic       btn_sp,
    input  logic       btn_clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t     state_r;
    logic       div_clk_r;
    logic       btn_sp_r;
    logic       btn_clr_r;
    logic [3:0] ones_r;
    logic [3:0] tens_r;
    logic       running_r;
    logic       wrap_r;

    logic       tick_s;
    logic       sp_evt_s;
    logic       clr_evt_s;
    logic       at_max_s;
    logic [3:0] next_ones_s;
    logic [3:0] next_tens_s;

    // Rising-edge events: a held level produces exactly one event.
    always_comb begin
        tick_s    = div_clk & ~div_clk_r;
        sp_evt_s  = btn_sp  & ~btn_sp_r;
        clr_evt_s = btn_clr & ~btn_clr_r;
    end

    // BCD successor of the current count, folding back to 00 at the terminal value.
    always_comb begin
        at_max_s    = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
        next_ones_s = ones_r;
        next_tens_s = tens_r;
        if (at_max_s) begin
            next_ones_s = 4'd0;
            next_tens_s = 4'd0;
        end else if (ones_r == 4'd9) begin
            next_ones_s = 4'd0;
            next_tens_s = tens_r + 4'd1;
        end else begin
            next_ones_s = ones_r + 4'd1;
            next_tens_s = tens_r;
        end
    end

    // Control FSM with registered count, running and wrap outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Edge detectors track the live inputs so release cannot fake an event.
            div_clk_r <= div_clk;
            btn_sp_r  <= btn_sp;
            btn_clr_r <= btn_clr;
            state_r   <= IDLE;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            div_clk_r <= div_clk;
            btn_sp_r  <= btn_sp;
            btn_clr_r <= btn_clr;
            wrap_r    <= 1'b0;
            if (clr_evt_s) begin
                state_r   <= IDLE;
                ones_r    <= 4'd0;
                tens_r    <= 4'd0;
                running_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        ones_r <= 4'd0;
                        tens_r <= 4'd0;
                        if (sp_evt_s) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick_s) begin
                            ones_r <= next_ones_s;
                            tens_r <= next_tens_s;
                            wrap_r <= at_max_s;
                        end
                        if (sp_evt_s) begin
                            state_r   <= PAUSE;
                            running_r <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        // Ticks are dropped here; only a start/pause event resumes.
                        if (sp_evt_s) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        ones_r    <= 4'd0;
                        tens_r    <= 4'd0;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ones    = ones_r;
    assign tens    = tens_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule
